syn_fgyrus_butterfly: RTL and testbench
=======================================

# syn_fgyrus_butterfly

Radix-2 decimation-in-time butterfly engine. It is the slave end of `syn_but_intf`, driven by the fusiform-gyrus FFT sequencer. It accepts one complex operand triplet (a, b, twiddle) per handshake and computes A' = a + b·w and B' = a − b·w in a fixed 4-stage pipeline. Both results return on the single `res` bus on consecutive cycles. The same datapath performs windowing: the sequencer drives a = 0, w = {window, 0}, and takes the first result (b·w).

## Interface
- `P_DATA_W`, 32: width of each real/imag component of sample_a, sample_b and res (signed two's complement).
- `P_TWDL_W`, 32: width of each twiddle component (signed).
- `P_TWDL_FRAC_W`, 30: fractional bits of twiddle. Q2.30 format, so 1.0 = 0x4000_0000.
- `P_BUT_DEL`, 4: latency from accept to first result. Fixed; any other value is illegal.

Ports:
- `clk_ir` in 1: clock.
- `rst_sync` in 1: synchronous reset, active-high.
- `sample_rdy` in 1: operand valid strobe (single cycle).
- `sample_a_re`, `sample_a_im` in P_DATA_W: operand a.
- `sample_b_re`, `sample_b_im` in P_DATA_W: operand b.
- `twdl_re`, `twdl_im` in P_TWDL_W: twiddle w.
- `but_rdy` out 1: engine can accept `sample_rdy` this cycle.
- `res_re`, `res_im` out P_DATA_W: result.
- `res_rdy` out 1: `res` valid.
- `res_sel` out 1: 0 = A', 1 = B'.
- `ovf_sticky` out 1: a saturation has occurred since reset or clear.
- `drop_sticky` out 1: `sample_rdy` arrived while `but_rdy` = 0.
- `clr_sticky` in 1: clears both sticky flags.

## Operation
- Accept: `sample_rdy & but_rdy`. The operands are registered in stage S1. `but_rdy` then drops for exactly one cycle, giving a throughput of 1 butterfly per 2 cycles.
- `sample_rdy` while `but_rdy` = 0:
  - The strobe is ignored; the pipeline is not disturbed.
  - `drop_sticky` ← 1.
- S2: four signed products b.re·w.re, b.im·w.im, b.re·w.im, b.im·w.re, at full width P_DATA_W+P_TWDL_W.
- S3:
  - p_re = rr − ii and p_im = ri + ir, each one bit wider than the products (no overflow possible).
  - Arithmetic shift right by P_TWDL_FRAC_W, which truncates toward −∞. No rounding.
  - Operand a is delayed alongside to align with p.
- S4:
  - sum = a + p and dif = a − p, computed at width P_DATA_W+3.
  - Each component saturates to [−2^(P_DATA_W−1), 2^(P_DATA_W−1)−1].
  - Any saturating component sets `ovf_sticky`.
  - A' drives `res` immediately. B' is held in a register and driven on the next cycle.
- Output sequencer (states IDLE_O, EMIT_B):
  - IDLE_O: when S4 is valid, `res` = A', `res_sel` = 0, `res_rdy` = 1, then go to EMIT_B.
  - EMIT_B: `res` = held B', `res_sel` = 1, `res_rdy` = 1, then return to IDLE_O.
  - A new S4-valid can coincide with EMIT_B only if the input rule is violated. The 1-cycle `but_rdy` gap guarantees it cannot.
- Sticky flags:
  - `clr_sticky` clears both flags.
  - If a set event occurs in the same cycle as `clr_sticky`, the set wins.
- There is no backpressure on `res`. The consumer must capture it on `res_rdy`.

## Timing
- Reset (`rst_sync` = 1 at a clock edge):
  - All valid bits, `res_rdy`, `res_sel`, both sticky flags and `res_re`/`res_im` go to 0.
  - `but_rdy` goes to 1 on the first cycle after reset deasserts.
  - The FSM goes to IDLE_O.
- Reset mid-operation: in-flight butterflies are discarded, and no `res_rdy` is issued for them.
- Accept at edge T:
  - `but_rdy` = 0 during cycle T+1 and returns to 1 in cycle T+2.
  - `res_rdy` = 1 with A' in cycle T+4, and with B' in cycle T+5.
- Back-to-back accepts at T and T+2 produce `res_rdy` continuously from T+4 to T+7, in the order A0, B0, A1, B1.
- `res_*` hold their last value when `res_rdy` = 0.

## Test plan
- Identity: a = (100, 0), b = (200, 0), w = (0x4000_0000, 0).
  - T+4: `res` = (300, 0), `res_sel` = 0.
  - T+5: `res` = (−100, 0), `res_sel` = 1.
  - `ovf_sticky` stays 0.
- Complex multiply: a = 0, b = (3, 4), w = (0, 0x4000_0000), i.e. j. Expect A' = (−4, 3) and B' = (4, −3).
- Truncation: a = (10, 0), b = (−3, 0), w = (0x2000_0000, 0), i.e. 0.5. p = −1.5 floors to −2, so A' = (8, 0) and B' = (12, 0).
- Saturation: a = (0x7FFF_FFF0, 0), b = (0x100, 0), w = 1.0.
  - A'.re = 0x7FFF_FFFF; B'.re = 0x7FFF_FEF0.
  - `ovf_sticky` = 1 until `clr_sticky`; a clear coinciding with a new overflow leaves it at 1.
- Throughput and drop:
  - Drive `sample_rdy` at T and T+1. The strobe at T+1 is ignored, `drop_sticky` = 1, and exactly two `res_rdy` pulses follow.
  - Accepts at T and T+2 give 4 contiguous `res_rdy` cycles in the order A0, B0, A1, B1.
- Reset mid-flight: assert `rst_sync` at T+2 after an accept at T. No `res_rdy` occurs at T+4 or T+5, and all outputs read 0.

Source files
------------

// File: rtl/syn_fgyrus_butterfly.sv
// rtl/syn_fgyrus_butterfly.sv - radix-2 DIT butterfly engine, A' = a + b*w, B' = a - b*w
module syn_fgyrus_butterfly #(
    parameter int P_DATA_W      = 32,
    parameter int P_TWDL_W      = 32,
    parameter int P_TWDL_FRAC_W = 30,
    parameter int P_BUT_DEL     = 4
) (
    input  logic                       clk_ir,
    input  logic                       rst_sync,
    input  logic                       sample_rdy,
    input  logic signed [P_DATA_W-1:0] sample_a_re,
    input  logic signed [P_DATA_W-1:0] sample_a_im,
    input  logic signed [P_DATA_W-1:0] sample_b_re,
    input  logic signed [P_DATA_W-1:0] sample_b_im,
    input  logic signed [P_TWDL_W-1:0] twdl_re,
    input  logic signed [P_TWDL_W-1:0] twdl_im,
    output logic                       but_rdy,
    output logic signed [P_DATA_W-1:0] res_re,
    output logic signed [P_DATA_W-1:0] res_im,
    output logic                       res_rdy,
    output logic                       res_sel,
    output logic                       ovf_sticky,
    output logic                       drop_sticky,
    input  logic                       clr_sticky
);

    // Full product width, and the working width of the final add/subtract.
    localparam int PW = P_DATA_W + P_TWDL_W;
    localparam int SW = P_DATA_W + 3;

    // The pipeline depth is hard-wired; refuse to elaborate any other latency.
    if (P_BUT_DEL != 4) begin : g_bad_but_del
        $error("syn_fgyrus_butterfly: P_BUT_DEL must be 4");
    end

    typedef enum logic {
        IDLE_O = 1'b0,
        EMIT_B = 1'b1
    } out_state_t;

    out_state_t state, state_nxt;

    logic accept;
    logic load_a;
    logic load_b;
    logic ovf_evt;
    logic drop_evt;

    // Stage S1: registered operands
    logic                       s1_valid;
    logic signed [P_DATA_W-1:0] s1_a_re, s1_a_im, s1_b_re, s1_b_im;
    logic signed [P_TWDL_W-1:0] s1_w_re, s1_w_im;

    // Stage S2: four partial products, a carried along
    logic                       s2_valid;
    logic signed [PW-1:0]       s2_rr, s2_ii, s2_ri, s2_ir;
    logic signed [P_DATA_W-1:0] s2_a_re, s2_a_im;

    // Stage S3: scaled complex product p = b*w, a carried along
    logic                       s3_valid;
    logic signed [SW-1:0]       s3_p_re, s3_p_im;
    logic signed [P_DATA_W-1:0] s3_a_re, s3_a_im;

    // Stage S4: sum/difference, saturated
    logic signed [SW-1:0]       sum_re, sum_im, dif_re, dif_im;
    logic signed [P_DATA_W-1:0] sat_sum_re, sat_sum_im, sat_dif_re, sat_dif_im;
    logic                       ovf_any;
    logic signed [P_DATA_W-1:0] hold_b_re, hold_b_im;

    // True when v does not fit in P_DATA_W signed bits.
    function automatic logic sat_ovf(input logic signed [SW-1:0] v);
        logic [SW-P_DATA_W:0] top;
        top = v[SW-1:P_DATA_W-1];
        return !((&top) || !(|top));
    endfunction

    // Clamp v into the P_DATA_W signed range.
    function automatic logic signed [P_DATA_W-1:0] sat_val(input logic signed [SW-1:0] v);
        logic signed [P_DATA_W-1:0] r;
        if (sat_ovf(v)) begin
            r = v[SW-1] ? {1'b1, {(P_DATA_W-1){1'b0}}} : {1'b0, {(P_DATA_W-1){1'b1}}};
        end else begin
            r = v[P_DATA_W-1:0];
        end
        return r;
    endfunction

    assign accept   = sample_rdy & but_rdy;
    assign drop_evt = sample_rdy & ~but_rdy;

    // Input acceptance: but_rdy drops for the single cycle after each accept.
    always_ff @(posedge clk_ir) begin
        if (rst_sync) begin
            s1_valid <= 1'b0;
            but_rdy  <= 1'b0;
        end else begin
            s1_valid <= accept;
            but_rdy  <= ~accept;
        end
    end

    // S1 operand capture; contents only matter while s1_valid is set.
    always_ff @(posedge clk_ir) begin
        if (accept) begin
            s1_a_re <= sample_a_re;
            s1_a_im <= sample_a_im;
            s1_b_re <= sample_b_re;
            s1_b_im <= sample_b_im;
            s1_w_re <= twdl_re;
            s1_w_im <= twdl_im;
        end
    end

    // Valid bits walk down the pipe; reset discards anything in flight.
    always_ff @(posedge clk_ir) begin
        if (rst_sync) begin
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
        end
    end

    // S2: full-width signed partial products.
    always_ff @(posedge clk_ir) begin
        s2_rr   <= PW'(s1_b_re) * PW'(s1_w_re);
        s2_ii   <= PW'(s1_b_im) * PW'(s1_w_im);
        s2_ri   <= PW'(s1_b_re) * PW'(s1_w_im);
        s2_ir   <= PW'(s1_b_im) * PW'(s1_w_re);
        s2_a_re <= s1_a_re;
        s2_a_im <= s1_a_im;
    end

    // S3: combine one bit wider, then drop the twiddle fraction (floor, no rounding).
    always_ff @(posedge clk_ir) begin
        s3_p_re <= SW'($signed({s2_rr[PW-1], s2_rr} - {s2_ii[PW-1], s2_ii}) >>> P_TWDL_FRAC_W);
        s3_p_im <= SW'($signed({s2_ri[PW-1], s2_ri} + {s2_ir[PW-1], s2_ir}) >>> P_TWDL_FRAC_W);
        s3_a_re <= s2_a_re;
        s3_a_im <= s2_a_im;
    end

    // S4: widened sum/difference and their saturated forms.
    always_comb begin
        sum_re     = SW'(s3_a_re) + s3_p_re;
        sum_im     = SW'(s3_a_im) + s3_p_im;
        dif_re     = SW'(s3_a_re) - s3_p_re;
        dif_im     = SW'(s3_a_im) - s3_p_im;
        sat_sum_re = sat_val(sum_re);
        sat_sum_im = sat_val(sum_im);
        sat_dif_re = sat_val(dif_re);
        sat_dif_im = sat_val(dif_im);
        ovf_any    = sat_ovf(sum_re) | sat_ovf(sum_im) | sat_ovf(dif_re) | sat_ovf(dif_im);
    end

    // Output sequencer state register.
    always_ff @(posedge clk_ir) begin
        if (rst_sync) begin
            state <= IDLE_O;
        end else begin
            state <= state_nxt;
        end
    end

    // Output sequencer: A' on the S4-valid cycle, held B' on the following one.
    always_comb begin
        state_nxt = state;
        load_a    = 1'b0;
        load_b    = 1'b0;
        case (state)
            IDLE_O: begin
                if (s3_valid) begin
                    load_a    = 1'b1;
                    state_nxt = EMIT_B;
                end
            end
            EMIT_B: begin
                load_b    = 1'b1;
                state_nxt = IDLE_O;
            end
            default: state_nxt = IDLE_O;
        endcase
    end

    assign ovf_evt = load_a & ovf_any;

    // B' is parked here while A' is on the bus.
    always_ff @(posedge clk_ir) begin
        if (load_a) begin
            hold_b_re <= sat_dif_re;
            hold_b_im <= sat_dif_im;
        end
    end

    // Result bus: updated only when a result is emitted, otherwise it holds.
    always_ff @(posedge clk_ir) begin
        if (rst_sync) begin
            res_rdy <= 1'b0;
            res_sel <= 1'b0;
            res_re  <= '0;
            res_im  <= '0;
        end else begin
            res_rdy <= load_a | load_b;
            res_sel <= load_b;
            if (load_a) begin
                res_re <= sat_sum_re;
                res_im <= sat_sum_im;
            end else if (load_b) begin
                res_re <= hold_b_re;
                res_im <= hold_b_im;
            end
        end
    end

    // Sticky flags: a set event in the same cycle as a clear wins.
    always_ff @(posedge clk_ir) begin
        if (rst_sync) begin
            ovf_sticky  <= 1'b0;
            drop_sticky <= 1'b0;
        end else begin
            if (ovf_evt) begin
                ovf_sticky <= 1'b1;
            end else if (clr_sticky) begin
                ovf_sticky <= 1'b0;
            end
            if (drop_evt) begin
                drop_sticky <= 1'b1;
            end else if (clr_sticky) begin
                drop_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_syn_fgyrus_butterfly.sv
// tb/tb_syn_fgyrus_butterfly.sv - self-checking bench for syn_fgyrus_butterfly
module tb_syn_fgyrus_butterfly;

    localparam int NC = 8192;
    localparam logic signed [127:0] MAXV = 128'sd2147483647;
    localparam logic signed [127:0] MINV = -128'sd2147483648;
    localparam logic [31:0] ONE = 32'h4000_0000;

    logic        clk_ir = 1'b0;
    logic        rst_sync = 1'b1;
    logic        sample_rdy = 1'b0;
    logic [31:0] sample_a_re = '0, sample_a_im = '0, sample_b_re = '0, sample_b_im = '0;
    logic [31:0] twdl_re = '0, twdl_im = '0;
    logic        clr_sticky = 1'b0;
    logic        but_rdy, res_rdy, res_sel, ovf_sticky, drop_sticky;
    logic [31:0] res_re, res_im;

    int errors = 0;
    int checks = 0;

    always #5 clk_ir = ~clk_ir;

    syn_fgyrus_butterfly #(
        .P_DATA_W(32), .P_TWDL_W(32), .P_TWDL_FRAC_W(30), .P_BUT_DEL(4)
    ) dut (
        .clk_ir(clk_ir), .rst_sync(rst_sync), .sample_rdy(sample_rdy),
        .sample_a_re(sample_a_re), .sample_a_im(sample_a_im),
        .sample_b_re(sample_b_re), .sample_b_im(sample_b_im),
        .twdl_re(twdl_re), .twdl_im(twdl_im),
        .but_rdy(but_rdy), .res_re(res_re), .res_im(res_im),
        .res_rdy(res_rdy), .res_sel(res_sel),
        .ovf_sticky(ovf_sticky), .drop_sticky(drop_sticky), .clr_sticky(clr_sticky)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void sat32(input logic signed [127:0] v, output logic [31:0] r, output bit ov);
        if (v > MAXV) begin
            r = 32'h7FFF_FFFF; ov = 1'b1;
        end else if (v < MINV) begin
            r = 32'h8000_0000; ov = 1'b1;
        end else begin
            r = v[31:0]; ov = 1'b0;
        end
    endfunction

    // Reference butterfly in wide integer arithmetic; >>> 30 is floor(x / 2^30).
    function automatic void bfly(input logic [31:0] ar, ai, br, bi, wr, wi,
                                 output logic [31:0] xr, xi, yr, yi, output bit ov);
        logic signed [127:0] sar, sai, sbr, sbi, swr, swi, pr, pi;
        bit o1, o2, o3, o4;
        sar = 128'($signed(ar)); sai = 128'($signed(ai));
        sbr = 128'($signed(br)); sbi = 128'($signed(bi));
        swr = 128'($signed(wr)); swi = 128'($signed(wi));
        pr = (sbr * swr - sbi * swi) >>> 30;
        pi = (sbr * swi + sbi * swr) >>> 30;
        sat32(sar + pr, xr, o1);
        sat32(sai + pi, xi, o2);
        sat32(sar - pr, yr, o3);
        sat32(sai - pi, yi, o4);
        ov = o1 | o2 | o3 | o4;
    endfunction

    // Behavioural model: a schedule of results indexed by clock edge number.
    bit          q_v[NC];
    bit          q_sel[NC];
    bit          q_ovf[NC];
    logic [31:0] q_re[NC];
    logic [31:0] q_im[NC];
    int          e = 0;
    bit          m_init = 1'b0;
    bit          m_bt = 1'b0, m_rdy = 1'b0, m_sel = 1'b0, m_ovf = 1'b0, m_drop = 1'b0;
    logic [31:0] m_re = '0, m_im = '0;
    logic [31:0] ma_r, ma_i, mb_r, mb_i;
    bit          m_acc, m_ov;

    always @(posedge clk_ir) begin
        if (rst_sync) begin
            for (int k = e; k < e + 5 && k < NC; k++) begin
                q_v[k] = 1'b0;
                q_ovf[k] = 1'b0;
            end
            m_rdy = 0; m_sel = 0; m_re = '0; m_im = '0;
            m_ovf = 0; m_drop = 0; m_bt = 0; m_init = 1'b1;
        end else begin
            m_acc = sample_rdy && m_bt;
            if (sample_rdy && !m_bt) m_drop = 1'b1;
            else if (clr_sticky) m_drop = 1'b0;
            if (m_acc && e + 4 < NC) begin
                bfly(sample_a_re, sample_a_im, sample_b_re, sample_b_im, twdl_re, twdl_im,
                     ma_r, ma_i, mb_r, mb_i, m_ov);
                q_v[e+3] = 1'b1; q_sel[e+3] = 1'b0; q_re[e+3] = ma_r; q_im[e+3] = ma_i;
                q_v[e+4] = 1'b1; q_sel[e+4] = 1'b1; q_re[e+4] = mb_r; q_im[e+4] = mb_i;
                q_ovf[e+3] = m_ov;
            end
            if (q_v[e]) begin
                m_rdy = 1'b1; m_sel = q_sel[e]; m_re = q_re[e]; m_im = q_im[e];
            end else begin
                m_rdy = 1'b0;
            end
            if (q_ovf[e]) m_ovf = 1'b1;
            else if (clr_sticky) m_ovf = 1'b0;
            m_bt = !m_acc;
        end
        e++;
    end

    // Compare process: every output against the model each cycle.
    always @(negedge clk_ir) begin
        if (m_init) begin
            check("res_rdy", 32'(res_rdy), 32'(m_rdy));
            if (m_rdy) check("res_sel", 32'(res_sel), 32'(m_sel));
            check("res_re", res_re, m_re);
            check("res_im", res_im, m_im);
            check("but_rdy", 32'(but_rdy), 32'(m_bt));
            check("ovf_sticky", 32'(ovf_sticky), 32'(m_ovf));
            check("drop_sticky", 32'(drop_sticky), 32'(m_drop));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_ir);
            #1;
        end
    endtask

    task automatic set_ops(input logic [31:0] ar, ai, br, bi, wr, wi);
        sample_a_re = ar; sample_a_im = ai;
        sample_b_re = br; sample_b_im = bi;
        twdl_re = wr; twdl_im = wi;
    endtask

    // One-cycle strobe; returns just after the accepting edge.
    task automatic op(input logic [31:0] ar, ai, br, bi, wr, wi);
        set_ops(ar, ai, br, bi, wr, wi);
        sample_rdy = 1'b1;
        @(posedge clk_ir);
        #1;
        sample_rdy = 1'b0;
    endtask

    // Called right after op(): checks A' three edges later and B' one edge after that.
    task automatic expect_pair(input string tag, input logic [31:0] xr, xi, yr, yi);
        idle(3);
        check({tag, "_a_rdy"}, 32'(res_rdy), 32'd1);
        check({tag, "_a_sel"}, 32'(res_sel), 32'd0);
        check({tag, "_a_re"}, res_re, xr);
        check({tag, "_a_im"}, res_im, xi);
        idle(1);
        check({tag, "_b_rdy"}, 32'(res_rdy), 32'd1);
        check({tag, "_b_sel"}, 32'(res_sel), 32'd1);
        check({tag, "_b_re"}, res_re, yr);
        check({tag, "_b_im"}, res_im, yi);
    endtask

    int          pulses;
    logic [31:0] rnd_a, rnd_b;

    initial begin
        // Reset state
        rst_sync = 1'b1;
        idle(3);
        check("rst_res_rdy", 32'(res_rdy), 32'd0);
        check("rst_res_re", res_re, 32'd0);
        check("rst_but_rdy", 32'(but_rdy), 32'd0);
        check("rst_ovf", 32'(ovf_sticky), 32'd0);
        check("rst_drop", 32'(drop_sticky), 32'd0);
        rst_sync = 1'b0;
        idle(1);
        check("post_rst_but_rdy", 32'(but_rdy), 32'd1);

        // Identity, complex multiply by j, truncation toward -inf
        idle(2);
        op(32'd100, 32'd0, 32'd200, 32'd0, ONE, 32'd0);
        check("accept_but_rdy_low", 32'(but_rdy), 32'd0);
        expect_pair("ident", 32'd300, 32'd0, 32'(-100), 32'd0);
        check("ident_ovf", 32'(ovf_sticky), 32'd0);
        idle(3);
        op(32'd0, 32'd0, 32'd3, 32'd4, 32'd0, ONE);
        expect_pair("cmul", 32'(-4), 32'd3, 32'd4, 32'(-3));
        idle(3);
        op(32'd10, 32'd0, 32'(-3), 32'd0, 32'h2000_0000, 32'd0);
        expect_pair("trunc", 32'd8, 32'd0, 32'd12, 32'd0);

        // Saturation, clear, then clear coinciding with a new overflow
        idle(3);
        op(32'h7FFF_FFF0, 32'd0, 32'h100, 32'd0, ONE, 32'd0);
        expect_pair("sat", 32'h7FFF_FFFF, 32'd0, 32'h7FFF_FEF0, 32'd0);
        check("sat_ovf_set", 32'(ovf_sticky), 32'd1);
        idle(2);
        check("sat_ovf_kept", 32'(ovf_sticky), 32'd1);
        clr_sticky = 1'b1;
        idle(1);
        clr_sticky = 1'b0;
        check("ovf_cleared", 32'(ovf_sticky), 32'd0);
        idle(2);
        clr_sticky = 1'b1;
        op(32'h7FFF_FFF0, 32'd0, 32'h100, 32'd0, ONE, 32'd0);
        idle(3);
        check("ovf_set_beats_clr", 32'(ovf_sticky), 32'd1);
        clr_sticky = 1'b0;
        idle(1);
        clr_sticky = 1'b1;
        idle(1);
        clr_sticky = 1'b0;

        // Back-to-back accepts two cycles apart: A0 B0 A1 B1 contiguous
        idle(3);
        op(32'd5, 32'd0, 32'd1, 32'd0, ONE, 32'd0);
        idle(1);
        op(32'd7, 32'd0, 32'd2, 32'd0, ONE, 32'd0);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] exp_seq [4];
            exp_seq = '{32'd6, 32'd4, 32'd9, 32'd5};
            idle(1);
            check("b2b_rdy", 32'(res_rdy), 32'd1);
            check("b2b_sel", 32'(res_sel), 32'(i % 2));
            check("b2b_re", res_re, exp_seq[i]);
        end

        // Strobe on two consecutive cycles: second one dropped
        idle(4);
        check("drop_before", 32'(drop_sticky), 32'd0);
        set_ops(32'd1, 32'd1, 32'd1, 32'd1, ONE, 32'd0);
        sample_rdy = 1'b1;
        idle(1);
        set_ops(32'd50, 32'd50, 32'd50, 32'd50, ONE, 32'd0);
        idle(1);
        sample_rdy = 1'b0;
        check("drop_set", 32'(drop_sticky), 32'd1);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            idle(1);
            if (res_rdy === 1'b1) pulses++;
        end
        check("drop_pulse_count", 32'(pulses), 32'd2);

        // Reset two cycles after an accept kills the butterfly
        idle(2);
        op(32'd9, 32'd9, 32'd9, 32'd9, ONE, ONE);
        idle(1);
        rst_sync = 1'b1;
        idle(1);
        rst_sync = 1'b0;
        check("midrst_but_rdy_low", 32'(but_rdy), 32'd0);
        idle(1);
        check("midrst_rdy_t4", 32'(res_rdy), 32'd0);
        check("midrst_re_t4", res_re, 32'd0);
        check("midrst_but_rdy_back", 32'(but_rdy), 32'd1);
        idle(1);
        check("midrst_rdy_t5", 32'(res_rdy), 32'd0);
        check("midrst_im_t5", res_im, 32'd0);
        check("midrst_drop", 32'(drop_sticky), 32'd0);

        // Randomized traffic checked by the model
        for (int c = 0; c < 2500; c++) begin
            sample_rdy = ($urandom_range(1) == 1);
            case ($urandom_range(3))
                0: set_ops($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
                1: begin
                    rnd_a = 32'($urandom_range(2000)) - 32'd1000;
                    rnd_b = 32'($urandom_range(2000)) - 32'd1000;
                    set_ops(rnd_a, rnd_b, rnd_b, rnd_a,
                            32'($urandom_range(32'h8000_0000)) - ONE,
                            32'($urandom_range(32'h8000_0000)) - ONE);
                end
                2: set_ops($urandom, $urandom, 32'($urandom_range(4000)) - 32'd2000,
                           32'($urandom_range(4000)) - 32'd2000, ONE, 32'(-32'sh4000_0000));
                default: set_ops(32'h7FFF_0000 + 32'($urandom_range(65535)),
                                 32'h8000_0000 + 32'($urandom_range(65535)),
                                 $urandom, $urandom, $urandom, $urandom);
            endcase
            clr_sticky = ($urandom_range(15) == 0);
            rst_sync = ($urandom_range(299) == 0);
            idle(1);
        end
        sample_rdy = 1'b0;
        clr_sticky = 1'b0;
        rst_sync = 1'b0;
        idle(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
